// File: rtl/vector_store_serializer.sv
// Vector store serializer: writes one latched vector line to the 32-bit
// data-memory write port as 4, 8 or 16 consecutive word writes. The
// pipeline is stalled until the last word is accepted and the done pulse
// has been issued.
module vector_store_serializer #(
  parameter int WORD_W = 32,
  parameter int VEC_W  = 512,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [VEC_W-1:0]  vec_data,
  input  logic [1:0]        VL,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wd,
  input  logic              mem_ready,
  output logic              stall,
  output logic              done
);

  localparam int NWORDS = VEC_W / WORD_W;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [1:0]         vl_q, vl_d;

  logic [WORD_W-1:0]  words [NWORDS];
  logic [IDX_W-1:0]   last_idx;
  logic [ADDR_W-1:0]  word_addr;

  // Slice the latched vector line into individually addressable words.
  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
    assign words[gi] = vec_q[gi*WORD_W +: WORD_W];
  end

  // Index of the final word for the latched length code (11 aliases 10).
  always_comb begin
    case (vl_q)
      2'b00:   last_idx = 4'd3;
      2'b01:   last_idx = 4'd7;
      default: last_idx = 4'd15;
    endcase
  end

  // Byte address of the current word; wraps modulo 2^ADDR_W by construction.
  assign word_addr = base_q + {{(ADDR_W-IDX_W-2){1'b0}}, idx_q, 2'b00};

  // State and request registers; reset abandons any store in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      base_q  <= '0;
      vl_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      base_q  <= base_d;
      vl_q    <= vl_d;
    end
  end

  // Next-state and output decode; outputs depend only on registered state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    base_d      = base_q;
    vl_d        = vl_q;
    start_ready = 1'b0;
    stall       = 1'b0;
    done        = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wd      = '0;
    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          vec_d   = vec_data;
          vl_d    = VL;
          base_d  = {base_addr[ADDR_W-1:2], 2'b00};
          idx_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        stall    = 1'b1;
        mem_we   = 1'b1;
        mem_addr = word_addr;
        mem_wd   = words[idx_q];
        // Without mem_ready everything holds so the same word is re-presented.
        if (mem_ready) begin
          if (idx_q == last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        stall   = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_store_serializer.sv
// Directed bench for vector_store_serializer: length codes, misalignment,
// backpressure, busy-ignore, address wrap and asynchronous reset mid-store.
module tb_vector_store_serializer;

  logic         clk;
  logic         reset;
  logic         start_valid;
  logic         start_ready;
  logic [31:0]  base_addr;
  logic [511:0] vec_data;
  logic [1:0]   VL;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wd;
  logic         mem_ready;
  logic         stall;
  logic         done;

  int n_checks;
  int n_errors;

  vector_store_serializer dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .base_addr   (base_addr),
    .vec_data    (vec_data),
    .VL          (VL),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .mem_ready   (mem_ready),
    .stall       (stall),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_vec(input logic [31:0] seed);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = seed + 32'(i);
    return v;
  endfunction

  // Present a request in an IDLE cycle and clock the accepting edge; then
  // scramble the request inputs (optionally leaving start_valid asserted).
  task automatic launch(input logic [31:0] base, input logic [1:0] vl,
                        input logic [31:0] seed, input bit keep,
                        input logic [31:0] next_base);
    start_valid = 1'b1;
    base_addr   = base;
    VL          = vl;
    vec_data    = mk_vec(seed);
    mem_ready   = 1'b1;
    tick();
    start_valid = keep;
    base_addr   = next_base;
    VL          = ~vl;
    vec_data    = mk_vec(32'hDEAD_0000);
  endtask

  // Starting at the sample point of cycle 1, follow a store through its
  // done pulse and into the following IDLE cycle.
  task automatic expect_store(input logic [31:0] base, input logic [1:0] vl,
                              input logic [31:0] seed, input int bp_first,
                              input int bp_last, input int exp_done);
    int          n;
    int          exp_idx;
    int          done_cyc;
    logic [31:0] base_al;
    logic [31:0] ea;
    n        = (vl == 2'b00) ? 4 : (vl == 2'b01) ? 8 : 16;
    base_al  = {base[31:2], 2'b00};
    exp_idx  = 0;
    done_cyc = 0;
    for (int c = 1; c <= 64 && done_cyc == 0; c++) begin
      mem_ready = !(c >= bp_first && c <= bp_last);
      if (exp_idx < n) begin
        ea = base_al + 32'(4 * exp_idx);
        check($sformatf("we c%0d", c),    64'(mem_we),      64'(1));
        check($sformatf("addr c%0d", c),  64'(mem_addr),    64'(ea));
        check($sformatf("wd c%0d", c),    64'(mem_wd),      64'(seed + 32'(exp_idx)));
        check($sformatf("stall c%0d", c), 64'(stall),       64'(1));
        check($sformatf("done c%0d", c),  64'(done),        64'(0));
        check($sformatf("rdy c%0d", c),   64'(start_ready), 64'(0));
        if (mem_ready) exp_idx++;
      end else begin
        check($sformatf("done c%0d", c),  64'(done),        64'(1));
        check($sformatf("we c%0d", c),    64'(mem_we),      64'(0));
        check($sformatf("stall c%0d", c), 64'(stall),       64'(1));
        check($sformatf("rdy c%0d", c),   64'(start_ready), 64'(0));
        done_cyc = c;
      end
      tick();
    end
    mem_ready = 1'b1;
    check("done_cycle",    64'(done_cyc),    64'(exp_done));
    check("idle rdy",      64'(start_ready), 64'(1));
    check("idle stall",    64'(stall),       64'(0));
    check("idle done",     64'(done),        64'(0));
    check("idle we",       64'(mem_we),      64'(0));
    $display("store base=%08h vl=%0d words=%0d done_cycle=%0d", base, vl, exp_idx, done_cyc);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b0;
    start_valid = 1'b0;
    base_addr   = '0;
    vec_data    = '0;
    VL          = 2'b00;
    mem_ready   = 1'b1;
    #1;
    check("rst we",    64'(mem_we),      64'(0));
    check("rst addr",  64'(mem_addr),    64'(0));
    check("rst wd",    64'(mem_wd),      64'(0));
    check("rst stall", 64'(stall),       64'(0));
    check("rst done",  64'(done),        64'(0));
    check("rst rdy",   64'(start_ready), 64'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Full 16-word store; inputs scrambled during WRITE must not matter.
    launch(32'h0000_0100, 2'b10, 32'hA000_0000, 1'b0, 32'h5555_5554);
    expect_store(32'h0000_0100, 2'b10, 32'hA000_0000, 0, -1, 17);

    // Short misaligned store, then length code 11 behaving as 16 words.
    launch(32'h0000_0203, 2'b00, 32'hC000_0000, 1'b0, 32'h1111_1110);
    expect_store(32'h0000_0203, 2'b00, 32'hC000_0000, 0, -1, 5);
    launch(32'h0000_0203, 2'b11, 32'hC100_0000, 1'b0, 32'h1111_1110);
    expect_store(32'h0000_0203, 2'b11, 32'hC100_0000, 0, -1, 17);

    // Backpressure on cycles 3..5: word 2 held at 0x108 until cycle 6.
    launch(32'h0000_0100, 2'b01, 32'hB000_0000, 1'b0, 32'h2222_2220);
    expect_store(32'h0000_0100, 2'b01, 32'hB000_0000, 3, 5, 12);

    // Busy ignore: a held request for 0x400 is taken only in the first IDLE cycle.
    launch(32'h0000_0300, 2'b00, 32'hD000_0000, 1'b1, 32'h0000_0400);
    expect_store(32'h0000_0300, 2'b00, 32'hD000_0000, 0, -1, 5);
    tick();
    start_valid = 1'b0;
    expect_store(32'h0000_0400, 2'b11, 32'hDEAD_0000, 0, -1, 17);

    // Address wrap past the top of the address space.
    launch(32'hFFFF_FFF8, 2'b00, 32'hE000_0000, 1'b0, 32'h3333_3330);
    expect_store(32'hFFFF_FFF8, 2'b00, 32'hE000_0000, 0, -1, 5);

    // Asynchronous reset in the middle of a store (idx = 5).
    launch(32'h0000_0100, 2'b10, 32'hF000_0000, 1'b0, 32'h4444_4440);
    repeat (5) tick();
    check("mid addr", 64'(mem_addr), 64'(32'h0000_0114));
    check("mid we",   64'(mem_we),   64'(1));
    reset = 1'b0;
    #1;
    check("arst we",    64'(mem_we),      64'(0));
    check("arst stall", 64'(stall),       64'(0));
    check("arst rdy",   64'(start_ready), 64'(1));
    check("arst done",  64'(done),        64'(0));
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post rdy", 64'(start_ready), 64'(1));
    check("post we",  64'(mem_we),      64'(0));
    $display("reset mid-store at idx=5");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
